// File: rtl/level_ctrl.sv
// level_ctrl: game-progress controller feeding the modulated clock divider.
// Counts scoring events (rising edges of Hit), tracks the run/pause/over flow,
// and raises the 4-bit Level code every PTS_PER_LVL points up to MAX_LVL.
// Every output is a register, so the divider only ever sees Level change on a
// clock edge and never through a combinational path from the game inputs.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no game; Level, Score and point counter forced to zero
// RUN    | game in progress; Hit edges score (Dead > Pause > Hit)
// PAUSED | game frozen; Level/Score/points held, Hit edges ignored
// OVER   | game ended; final Level/Score held until the next Start

module level_ctrl #(
    parameter int PTS_PER_LVL = 5,
    parameter int START_LVL   = 1,
    parameter int MAX_LVL     = 10,
    parameter int SCORE_W     = 10
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Pause,
    input  logic               Hit,
    input  logic               Dead,
    output logic [3:0]         Level,
    output logic [SCORE_W-1:0] Score,
    output logic               LvlUp,
    output logic [1:0]         State
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    localparam logic [3:0]         LVL_START = 4'(START_LVL);
    localparam logic [3:0]         LVL_MAX   = 4'(MAX_LVL);
    localparam logic [7:0]         PTS_LAST  = 8'(PTS_PER_LVL - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [3:0]         level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         pts_q,   pts_d;
    logic               lvlup_q, lvlup_d;
    logic               hit_q,   hit_d;
    logic               hit_edge;

    // Only a fresh 0->1 transition of Hit scores; the delay register runs in
    // every state so a Hit held across PAUSED->RUN does not count.
    assign hit_edge = Hit & ~hit_q;

    // Next-state and next-output computation for the game flow.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        score_d = score_q;
        pts_d   = pts_q;
        lvlup_d = 1'b0;
        hit_d   = Hit;

        case (state_q)
            ST_IDLE: begin
                level_d = 4'd0;
                score_d = '0;
                pts_d   = 8'd0;
                if (Start) begin
                    state_d = ST_RUN;
                    level_d = LVL_START;
                end
            end

            ST_RUN: begin
                if (Dead) begin
                    state_d = ST_OVER;
                end else if (Pause) begin
                    state_d = ST_PAUSED;
                end else if (hit_edge) begin
                    // Score saturates, but level progression keeps going.
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    if (pts_q == PTS_LAST) begin
                        pts_d = 8'd0;
                        if (level_q < LVL_MAX) begin
                            level_d = level_q + 4'd1;
                            lvlup_d = 1'b1;
                        end
                    end else begin
                        pts_d = pts_q + 8'd1;
                    end
                end
            end

            ST_PAUSED: begin
                if (Dead) begin
                    state_d = ST_OVER;
                end else if (!Pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_OVER: begin
                // Final score stays visible and the divider keeps its rate
                // until a new game starts.
                if (Start) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    pts_d   = 8'd0;
                    level_d = LVL_START;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            level_q <= 4'd0;
            score_q <= '0;
            pts_q   <= 8'd0;
            lvlup_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            score_q <= score_d;
            pts_q   <= pts_d;
            lvlup_q <= lvlup_d;
            hit_q   <= hit_d;
        end
    end

    assign Level = level_q;
    assign Score = score_q;
    assign LvlUp = lvlup_q;
    assign State = state_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: stimulus pushes the expected outputs for
// the following clock edge into a queue; a monitor on the falling edge pops
// and compares. A second instance with SCORE_W=4 covers score saturation.

module tb_level_ctrl;

    logic       Clk = 1'b0;
    int         cyc = 0;

    logic       rst_a = 1'b1, start_a = 1'b0, pause_a = 1'b0, hit_a = 1'b0, dead_a = 1'b0;
    logic [3:0] level_a;
    logic [9:0] score_a;
    logic       lvlup_a;
    logic [1:0] state_a;

    logic       rst_b = 1'b1, start_b = 1'b0, pause_b = 1'b0, hit_b = 1'b0, dead_b = 1'b0;
    logic [3:0] level_b;
    logic [3:0] score_b;
    logic       lvlup_b;
    logic [1:0] state_b;

    level_ctrl #(.PTS_PER_LVL(5), .START_LVL(1), .MAX_LVL(10), .SCORE_W(10)) dut_a (
        .Clk(Clk), .Rst(rst_a), .Start(start_a), .Pause(pause_a), .Hit(hit_a), .Dead(dead_a),
        .Level(level_a), .Score(score_a), .LvlUp(lvlup_a), .State(state_a)
    );

    level_ctrl #(.PTS_PER_LVL(5), .START_LVL(1), .MAX_LVL(10), .SCORE_W(4)) dut_b (
        .Clk(Clk), .Rst(rst_b), .Start(start_b), .Pause(pause_b), .Hit(hit_b), .Dead(dead_b),
        .Level(level_b), .Score(score_b), .LvlUp(lvlup_b), .State(state_b)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        bit    sel;
        string name;
        int    st;
        int    lvl;
        int    sc;
        int    up;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expected outputs after the next active edge.
    task automatic push(input bit sel, input string name, input int st, input int lvl,
                        input int sc, input int up);
        exp_t e;
        e.at   = cyc + 1;
        e.sel  = sel;
        e.name = name;
        e.st   = st;
        e.lvl  = lvl;
        e.sc   = sc;
        e.up   = up;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every entry due at this cycle, flag any left stale.
    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            int gst, glvl, gsc, gup;
            e    = sb.pop_front();
            gst  = e.sel ? int'(state_b) : int'(state_a);
            glvl = e.sel ? int'(level_b) : int'(level_a);
            gsc  = e.sel ? int'(score_b) : int'(score_a);
            gup  = e.sel ? int'(lvlup_b) : int'(lvlup_a);
            checks++;
            if (e.at != cyc || gst != e.st || glvl != e.lvl || gsc != e.sc || gup != e.up) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d got st=%0d lvl=%0d sc=%0d up=%0d want st=%0d lvl=%0d sc=%0d up=%0d",
                         e.name, cyc, e.at, gst, glvl, gsc, gup, e.st, e.lvl, e.sc, e.up);
            end
        end
    end

    initial begin
        int lvl, sc, up;

        // 1. Reset, then Start
        tick();
        push(0, "reset", 0, 0, 0, 0);
        tick();
        rst_a = 1'b0;
        push(0, "idle_hold", 0, 0, 0, 0);
        tick();
        start_a = 1'b1;
        push(0, "start", 1, 1, 0, 0);
        tick();
        start_a = 1'b0;

        // 2. Five single-cycle Hit pulses
        for (int i = 1; i <= 5; i++) begin
            hit_a = 1'b1;
            push(0, "hit5_edge", 1, (i == 5) ? 2 : 1, i, (i == 5) ? 1 : 0);
            tick();
            hit_a = 1'b0;
            push(0, "hit5_after", 1, (i == 5) ? 2 : 1, i, 0);
            tick();
            tick();
            tick();
        end

        // 3. Hit held high for 20 cycles counts once
        hit_a = 1'b1;
        push(0, "hold_first", 1, 2, 6, 0);
        tick();
        repeat (18) tick();
        push(0, "hold_last", 1, 2, 6, 0);
        tick();
        hit_a = 1'b0;
        tick();

        // Pause with Hit pulses ignored
        pause_a = 1'b1;
        push(0, "pause_enter", 2, 2, 6, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            hit_a = 1'b1;
            push(0, "pause_hit", 2, 2, 6, 0);
            tick();
            hit_a = 1'b0;
            tick();
        end
        hit_a = 1'b1;
        tick();
        pause_a = 1'b0;
        push(0, "resume_held_hit", 1, 2, 6, 0);
        tick();
        push(0, "resume_no_count", 1, 2, 6, 0);
        tick();
        hit_a = 1'b0;
        tick();

        // Dead -> OVER, Pause ignored in OVER, restart
        dead_a = 1'b1;
        push(0, "dead_over", 3, 2, 6, 0);
        tick();
        dead_a  = 1'b0;
        pause_a = 1'b1;
        push(0, "over_ignores_pause", 3, 2, 6, 0);
        tick();
        pause_a = 1'b0;
        start_a = 1'b1;
        push(0, "restart", 1, 1, 0, 0);
        tick();
        start_a = 1'b0;

        // 5. Score=3, then Hit edge coincident with Dead
        for (int i = 1; i <= 3; i++) begin
            hit_a = 1'b1;
            push(0, "pre_dead_hit", 1, 1, i, 0);
            tick();
            hit_a = 1'b0;
            tick();
        end
        hit_a  = 1'b1;
        dead_a = 1'b1;
        push(0, "dead_beats_hit", 3, 1, 3, 0);
        tick();
        hit_a  = 1'b0;
        dead_a = 1'b0;
        push(0, "over_hold", 3, 1, 3, 0);
        tick();
        start_a = 1'b1;
        push(0, "over_restart", 1, 1, 0, 0);
        tick();
        start_a = 1'b0;

        // 4. Fifty pulses: Level saturates at 10 on the 45th
        for (int i = 1; i <= 50; i++) begin
            lvl = 1 + i / 5;
            if (lvl > 10) lvl = 10;
            up = ((i % 5) == 0 && i <= 45) ? 1 : 0;
            hit_a = 1'b1;
            push(0, "run50_edge", 1, lvl, i, up);
            tick();
            hit_a = 1'b0;
            push(0, "run50_low", 1, lvl, i, 0);
            tick();
        end

        // 6. Mid-game reset with Score=7, Level=2
        rst_a = 1'b1;
        push(0, "rst_after50", 0, 0, 0, 0);
        tick();
        rst_a   = 1'b0;
        start_a = 1'b1;
        push(0, "start2", 1, 1, 0, 0);
        tick();
        start_a = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            hit_a = 1'b1;
            push(0, "hit7", 1, (i >= 5) ? 2 : 1, i, (i == 5) ? 1 : 0);
            tick();
            hit_a = 1'b0;
            tick();
        end
        rst_a = 1'b1;
        hit_a = 1'b1;
        push(0, "rst_midrun", 0, 0, 0, 0);
        tick();
        rst_a = 1'b0;
        hit_a = 1'b0;
        tick();

        // Start and Dead together in IDLE: Start wins, Dead acts next cycle
        start_a = 1'b1;
        dead_a  = 1'b1;
        push(0, "start_vs_dead", 1, 1, 0, 0);
        tick();
        start_a = 1'b0;
        push(0, "dead_next", 3, 1, 0, 0);
        tick();
        dead_a = 1'b0;

        // SCORE_W=4 instance: saturation at 15, Level still reaches 5
        push(1, "b_reset", 0, 0, 0, 0);
        tick();
        rst_b   = 1'b0;
        start_b = 1'b1;
        push(1, "b_start", 1, 1, 0, 0);
        tick();
        start_b = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            sc  = (i > 15) ? 15 : i;
            lvl = 1 + i / 5;
            up  = ((i % 5) == 0) ? 1 : 0;
            hit_b = 1'b1;
            push(1, "b_sat_edge", 1, lvl, sc, up);
            tick();
            hit_b = 1'b0;
            push(1, "b_sat_low", 1, lvl, sc, 0);
            tick();
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
